bcd_to_binary: RTL

- Sequential multi-digit packed-BCD to unsigned-binary converter; inverse direction of the team's binary-to-BCD decoder.
- Uses reverse double-dabble: one shift-right plus per-digit "subtract 3 if >= 8" per clock.
- Sits between BCD entry logic (keypad / switches) and binary arithmetic datapaths.
- Start/ready/done handshake; flags invalid BCD digits instead of producing a value.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit_adjust.sv | 13 +
 rtl/bcd_to_binary.sv | 101 ++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the packed-BCD to binary converter.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    function automatic logic is_bcd_digit(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble digit correction: a digit that received a shifted-in 8 is pulled back by 3.
// Latency: combinational.
// Backpressure: none.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd_to_binary.sv
// Packed-BCD to unsigned binary converter, one reverse double-dabble step per clock.
// Latency: done 4*DIGITS cycles after accept (next cycle for an invalid operand).
// Backpressure: start is taken only while ready; start while busy is dropped.
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                          ready,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bin_out,
    output logic                          err
);

    localparam int W  = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(W);

    conv_state_t   state;
    conv_state_t   state_nxt;
    logic [W-1:0]  bcd_reg;
    logic [W-1:0]  bin_reg;
    logic [CW-1:0] cnt;
    logic [W-1:0]  bcd_shr;
    logic [W-1:0]  bcd_adj;
    logic [W-1:0]  bin_shr;
    logic          operand_ok;

    always_comb begin
        operand_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit(bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W])) begin
                operand_ok = 1'b0;
            end
        end
    end

    // The combined {bcd_reg, bin_reg} shifts right; digits are corrected after the shift.
    assign bcd_shr = {1'b0, bcd_reg[W-1:1]};
    assign bin_shr = {bcd_reg[0], bin_reg[W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (bcd_shr[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .dout (bcd_adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = operand_ok ? SHIFT : DONE;
            SHIFT:   if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        bcd_reg <= bcd_in;
                        bin_reg <= '0;
                        cnt     <= CW'(W - 1);
                        if (!operand_ok) begin
                            bin_out <= '0;
                            err     <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    bcd_reg <= bcd_adj;
                    bin_reg <= bin_shr;
                    cnt     <= cnt - 1'b1;
                    if (cnt == '0) begin
                        bin_out <= bin_shr;
                        err     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
